sr_ff_bank: RTL and testbench

- Parametrised multi-channel successor to the single-bit SR flip-flop.
- Holds WIDTH independent storage bits. One shared mode input selects SR, JK, D or T behaviour for all channels.
- Adds a defined policy for the SR 11 input (never drives Z), per-channel sticky illegal-input flags, and a one-cycle illegal-event pulse.
- Used as a general register/flag bank in control paths.

---
 rtl/sr_ff_bank.sv | 143 ++++++++++++++
 tb/tb_sr_ff_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Multi-channel SR/JK/D/T flip-flop bank with sticky illegal-input flags.
// Optional illegal-event counter enabled by defining SR_FF_BANK_ERR_CNT_EN.
module sr_ff_bank #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int              SR_POLICY = 0,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_illegal,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] illegal,
    output logic             illegal_pulse
`ifdef SR_FF_BANK_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // Out-of-range policy values collapse to hold.
    localparam logic [1:0] POLICY = (SR_POLICY == 1) ? 2'd1 :
                                    (SR_POLICY == 2) ? 2'd2 : 2'd0;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic [WIDTH-1:0] illegal_r;
    logic             pulse_r;
    logic [WIDTH-1:0] next_q_s;
    logic [WIDTH-1:0] evt_s;
    logic [WIDTH-1:0] illegal_nxt_s;
    logic             any_evt_s;

    function automatic logic next_bit(input logic [1:0] md, input logic cur,
                                      input logic ai, input logic bi);
        logic nb;
        case (md)
            MODE_SR: begin
                case ({ai, bi})
                    2'b01:   nb = 1'b0;
                    2'b10:   nb = 1'b1;
                    2'b11: begin
                        case (POLICY)
                            2'd1:    nb = 1'b1;
                            2'd2:    nb = 1'b0;
                            default: nb = cur;
                        endcase
                    end
                    default: nb = cur;
                endcase
            end
            MODE_JK: begin
                case ({ai, bi})
                    2'b01:   nb = 1'b0;
                    2'b10:   nb = 1'b1;
                    2'b11:   nb = ~cur;
                    default: nb = cur;
                endcase
            end
            MODE_D:  nb = ai;
            MODE_T:  nb = cur ^ ai;
            default: nb = cur;
        endcase
        return nb;
    endfunction

    // Per-channel next state and illegal-event detection.
    always_comb begin
        next_q_s = q_r;
        evt_s    = {WIDTH{1'b0}};
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                next_q_s[i] = next_bit(mode, q_r[i], a[i], b[i]);
                evt_s[i]    = (mode == MODE_SR) && a[i] && b[i];
            end
        end else begin
            next_q_s = q_r;
            evt_s    = {WIDTH{1'b0}};
        end
    end

    // Sticky flag update; a coincident event beats the clear.
    always_comb begin
        illegal_nxt_s = illegal_r;
        if (clr_illegal) begin
            illegal_nxt_s = evt_s;
        end else begin
            illegal_nxt_s = illegal_r | evt_s;
        end
    end

    assign any_evt_s = |evt_s;

    // State, complement, flags and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= RESET_VAL;
            qb_r      <= ~RESET_VAL;
            illegal_r <= {WIDTH{1'b0}};
            pulse_r   <= 1'b0;
        end else begin
            q_r       <= next_q_s;
            qb_r      <= ~next_q_s;
            illegal_r <= illegal_nxt_s;
            pulse_r   <= any_evt_s;
        end
    end

    assign q             = q_r;
    assign qb            = qb_r;
    assign illegal       = illegal_r;
    assign illegal_pulse = pulse_r;

`ifdef SR_FF_BANK_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturating count of edges carrying at least one illegal event.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_illegal) begin
            cnt_r <= any_evt_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (any_evt_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign err_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: three instances, one per SR_POLICY,
// sharing stimulus; RESET_VAL = A5 and CNT_W = 2.
module tb_sr_ff_bank;

    localparam int NI = 3;

    typedef struct {
        logic [7:0] q;
        logic [7:0] qb;
        logic [7:0] ill;
        logic       p;
        logic [1:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       clr_illegal = 1'b0;

    logic [7:0] q_o   [NI];
    logic [7:0] qb_o  [NI];
    logic [7:0] ill_o [NI];
    logic       p_o   [NI];
    logic [1:0] cnt_o [NI];

    logic [7:0] mq   [NI];
    logic [7:0] mill [NI];
    logic       mp   [NI];
    logic [1:0] mcnt [NI];

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        sr_ff_bank #(
            .WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(k), .CNT_W(2)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
            .clr_illegal(clr_illegal),
            .q(q_o[k]), .qb(qb_o[k]), .illegal(ill_o[k]),
            .illegal_pulse(p_o[k])
`ifdef SR_FF_BANK_ERR_CNT_EN
            , .err_cnt(cnt_o[k])
`endif
        );
`ifndef SR_FF_BANK_ERR_CNT_EN
        assign cnt_o[k] = 2'd0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model, written as set/reset/both bit masks.
    task automatic model(input int k);
        logic [7:0] set, rs, both, nq, evt;
        set  = a & ~b;
        rs   = ~a & b;
        both = a & b;
        evt  = 8'h00;
        nq   = mq[k];
        if (en) begin
            if (mode == 2'b00) begin
                nq  = (mq[k] & ~rs) | set;
                if (k == 1) nq = nq | both;
                if (k == 2) nq = nq & ~both;
                evt = both;
            end else if (mode == 2'b01) begin
                nq = set | (mq[k] & ~rs & ~both) | (~mq[k] & both);
            end else if (mode == 2'b10) begin
                nq = a;
            end else begin
                nq = mq[k] ^ a;
            end
        end
        if (rst) begin
            mq[k] = 8'hA5; mill[k] = 8'h00; mp[k] = 1'b0; mcnt[k] = 2'd0;
        end else begin
            mq[k]   = nq;
            mill[k] = clr_illegal ? evt : (mill[k] | evt);
            mp[k]   = (evt != 8'h00);
            if (clr_illegal) mcnt[k] = (evt != 8'h00) ? 2'd1 : 2'd0;
            else if ((evt != 8'h00) && (mcnt[k] != 2'd3)) mcnt[k] = mcnt[k] + 2'd1;
        end
`ifdef SR_FF_BANK_ERR_CNT_EN
        sb.push_back('{q: mq[k], qb: ~mq[k], ill: mill[k], p: mp[k], c: mcnt[k]});
`else
        sb.push_back('{q: mq[k], qb: ~mq[k], ill: mill[k], p: mp[k], c: 2'd0});
`endif
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] av, input logic [7:0] bv, input logic c);
        exp_t ex;
        rst = r; en = e; mode = m; a = av; b = bv; clr_illegal = c;
        for (int k = 0; k < NI; k++) model(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            ex = sb.pop_front();
            check($sformatf("q%0d", k), {24'd0, q_o[k]}, {24'd0, ex.q});
            check($sformatf("qb%0d", k), {24'd0, qb_o[k]}, {24'd0, ex.qb});
            check($sformatf("ill%0d", k), {24'd0, ill_o[k]}, {24'd0, ex.ill});
            check($sformatf("pulse%0d", k), {31'd0, p_o[k]}, {31'd0, ex.p});
            check($sformatf("cnt%0d", k), {30'd0, cnt_o[k]}, {30'd0, ex.c});
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            mq[k] = 8'h00; mill[k] = 8'h00; mp[k] = 1'b0; mcnt[k] = 2'd0;
        end
        @(negedge clk);
        step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        check("rst_q", {24'd0, q_o[0]}, 32'hA5);
        check("rst_qb", {24'd0, qb_o[0]}, 32'h5A);
        step(1'b0, 1'b1, 2'b11, 8'hFF, 8'h00, 1'b0);
        check("t_tog", {24'd0, q_o[0]}, 32'h5A);
        step(1'b1, 1'b1, 2'b11, 8'hFF, 8'h00, 1'b1);
        check("rst_mid", {24'd0, q_o[0]}, 32'hA5);

        step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'b00, 8'h0F, 8'hF0, 1'b0);
        check("sr_set", {24'd0, q_o[0]}, 32'h0F);
        step(1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
        check("sr11_p0", {24'd0, q_o[0]}, 32'h0F);
        check("sr11_p1", {24'd0, q_o[1]}, 32'hFF);
        check("sr11_p2", {24'd0, q_o[2]}, 32'h00);
        check("sr11_ill", {24'd0, ill_o[0]}, 32'hFF);
        check("sr11_pls", {31'd0, p_o[0]}, 32'd1);
        step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        check("pls_drop", {31'd0, p_o[0]}, 32'd0);

        step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        check("clr_en0", {24'd0, ill_o[0]}, 32'h00);
        step(1'b0, 1'b1, 2'b10, 8'h3C, 8'h00, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0);
            check("jk_tog", {24'd0, q_o[0]}, (n % 2 == 0) ? 32'hC3 : 32'h3C);
            check("jk_ill", {24'd0, ill_o[0]}, 32'h00);
        end

        step(1'b0, 1'b1, 2'b10, 8'h5A, 8'h00, 1'b0);
        check("d_load", {24'd0, q_o[0]}, 32'h5A);
        step(1'b0, 1'b1, 2'b11, 8'h0F, 8'h00, 1'b0);
        check("t_mode", {24'd0, q_o[0]}, 32'h55);
        step(1'b0, 1'b0, 2'b11, 8'hFF, 8'h00, 1'b0);
        check("en0_hold", {24'd0, q_o[0]}, 32'h55);
        step(1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0);
        check("en0_noill", {24'd0, ill_o[0]}, 32'h00);

        step(1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
        check("race_pre", {24'd0, ill_o[0]}, 32'h01);
        step(1'b0, 1'b1, 2'b00, 8'h02, 8'h02, 1'b1);
        check("race_set", {24'd0, ill_o[0]}, 32'h02);
        step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
        check("race_clr", {24'd0, ill_o[0]}, 32'h00);

        for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 2'b00, 8'h81, 8'h81, 1'b0);
        step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1);

        for (int n = 0; n < 60; n++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
